// File: rtl/fetch_if.sv
// Fetch-stage bundle: instmem read port, decode handshake and redirect.
// master = fetch unit side, slave = instmem/decode/branch side.
interface fetch_if;
  logic        run;
  logic [11:0] addIM;
  logic [15:0] outIM;
  logic [15:0] inst_out;
  logic        inst_valid;
  logic        inst_ready;
  logic [11:0] pc_out;
  logic        br_taken;
  logic [11:0] br_target;
  logic        halted;

  modport master (
    input  run, outIM, inst_ready, br_taken, br_target,
    output addIM, inst_out, inst_valid, pc_out, halted
  );

  modport slave (
    output run, outIM, inst_ready, br_taken, br_target,
    input  addIM, inst_out, inst_valid, pc_out, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a registered-read instmem.
// Optional HALT-opcode stop is built when FETCH_HALT_EN is defined.
module fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus
);

  logic [11:0] pc_f;
  logic [11:0] pc_d;
  logic        vld;
  logic        halted;
  logic        halt_hit;
  logic        adv;

`ifdef FETCH_HALT_EN
  assign halt_hit = vld & bus.inst_ready & (bus.outIM[15:12] == 4'hF);

  // Once halted, only a redirect (or reset) restarts fetching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (bus.br_taken) begin
      halted <= 1'b0;
    end else if (halt_hit) begin
      halted <= 1'b1;
    end
  end
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  assign adv = bus.run & ~halted & (~vld | bus.inst_ready) & ~halt_hit;

  // While an unaccepted word sits on outIM, re-read its address so it stays put.
  assign bus.addIM      = (vld & ~adv) ? pc_d : pc_f;
  assign bus.inst_out   = bus.outIM;
  assign bus.inst_valid = vld;
  assign bus.pc_out     = pc_d;
  assign bus.halted     = halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f <= RESET_PC;
      pc_d <= 12'h000;
      vld  <= 1'b0;
    end else if (bus.br_taken) begin
      pc_f <= bus.br_target;
      vld  <= 1'b0;
    end else if (halt_hit) begin
      vld  <= 1'b0;
    end else if (adv) begin
      pc_d <= pc_f;
      pc_f <= pc_f + 12'd1;
      vld  <= 1'b1;
    end else if (vld & bus.inst_ready) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, halt/reset sequences,
// then randomized traffic against an instruction-stream reference model.
module tb_fetch_unit;

  logic clk;
  logic rst;
  fetch_if bus ();

  fetch_unit #(.RESET_PC(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];

  // Behavioural instmem: registered read, one edge of latency.
  always @(posedge clk) bus.outIM <= mem[bus.addIM];

  int checks;
  int failures;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  typedef struct packed {
    logic        run;
    logic        rdy;
    logic        br;
    logic [11:0] tgt;
    logic        e_valid;
    logic [11:0] e_pc;
    logic [15:0] e_inst;
    logic [11:0] e_addr;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic run, input logic rdy, input logic br,
                              input logic [11:0] tgt, input logic ev,
                              input logic [11:0] epc, input logic [15:0] einst,
                              input logic [11:0] eaddr);
    vec_t v;
    v.run = run; v.rdy = rdy; v.br = br; v.tgt = tgt;
    v.e_valid = ev; v.e_pc = epc; v.e_inst = einst; v.e_addr = eaddr;
    return v;
  endfunction

  task automatic drive(input logic run, input logic rdy, input logic br, input logic [11:0] tgt);
    bus.run        = run;
    bus.inst_ready = rdy;
    bus.br_taken   = br;
    bus.br_target  = tgt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [11:0] epc,
                            input logic [15:0] einst, input logic [11:0] eaddr,
                            input logic ehalt);
    chk({tag, ".valid"}, 16'(bus.inst_valid), 16'(ev));
    if (ev) begin
      chk({tag, ".pc"},   16'(bus.pc_out), 16'(epc));
      chk({tag, ".inst"}, bus.inst_out,    einst);
    end
    chk({tag, ".addr"},   16'(bus.addIM),  16'(eaddr));
    chk({tag, ".halted"}, 16'(bus.halted), 16'(ehalt));
  endtask

  // Reference model state for the random phase.
  logic [11:0] exp_pc;
  logic        prev_run, prev_rdy, prev_br, prev_valid;
  logic [11:0] prev_tgt;

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h5000 | 16'(i);
    mem[12'h000] = 16'h0234;
    mem[12'h001] = 16'h0381;
    mem[12'h002] = 16'h1111;
    mem[12'h003] = 16'hF000;
    mem[12'h004] = 16'h4444;
    mem[12'h008] = 16'h2222;
    mem[12'hFFE] = 16'hAFFE;
    mem[12'hFFF] = 16'hBFFF;

    vecs[0]  = mk(1, 1, 0, 12'h000, 0, 12'h000, 16'h0000, 12'h000);
    vecs[1]  = mk(1, 1, 0, 12'h000, 1, 12'h000, 16'h0234, 12'h001);
    vecs[2]  = mk(1, 0, 0, 12'h000, 1, 12'h001, 16'h0381, 12'h001);
    vecs[3]  = mk(1, 0, 0, 12'h000, 1, 12'h001, 16'h0381, 12'h001);
    vecs[4]  = mk(1, 0, 0, 12'h000, 1, 12'h001, 16'h0381, 12'h001);
    vecs[5]  = mk(1, 1, 0, 12'h000, 1, 12'h001, 16'h0381, 12'h002);
    vecs[6]  = mk(1, 1, 1, 12'h008, 1, 12'h002, 16'h1111, 12'h003);
    vecs[7]  = mk(1, 1, 0, 12'h000, 0, 12'h000, 16'h0000, 12'h008);
    vecs[8]  = mk(1, 1, 1, 12'hFFE, 1, 12'h008, 16'h2222, 12'h009);
    vecs[9]  = mk(1, 1, 0, 12'h000, 0, 12'h000, 16'h0000, 12'hFFE);
    vecs[10] = mk(1, 1, 0, 12'h000, 1, 12'hFFE, 16'hAFFE, 12'hFFF);
    vecs[11] = mk(1, 1, 0, 12'h000, 1, 12'hFFF, 16'hBFFF, 12'h000);
    vecs[12] = mk(1, 1, 0, 12'h000, 1, 12'h000, 16'h0234, 12'h001);
    vecs[13] = mk(0, 0, 0, 12'h000, 1, 12'h001, 16'h0381, 12'h001);
    vecs[14] = mk(0, 1, 0, 12'h000, 1, 12'h001, 16'h0381, 12'h001);
    vecs[15] = mk(0, 1, 0, 12'h000, 0, 12'h000, 16'h0000, 12'h002);
    vecs[16] = mk(1, 1, 0, 12'h000, 0, 12'h000, 16'h0000, 12'h002);
    vecs[17] = mk(1, 1, 0, 12'h000, 1, 12'h002, 16'h1111, 12'h003);

    // Reset state
    drive(0, 0, 0, 12'h000);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 12'h000, 16'h0000, 12'h000, 0);
    rst = 1'b0;

    // Directed table: streaming, stall, redirect, wrap, run=0 with pending word
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].run, vecs[i].rdy, vecs[i].br, vecs[i].tgt);
      #1;
      expect_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                 vecs[i].e_inst, vecs[i].e_addr, 1'b0);
      next_cycle();
    end

`ifdef FETCH_HALT_EN
    drive(1, 1, 0, 12'h000); #1;
    expect_out("halt.hit", 1, 12'h003, 16'hF000, 12'h003, 0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 12'h000); #1;
      expect_out($sformatf("halt.idle%0d", i), 0, 12'h000, 16'h0000, 12'h004, 1);
      next_cycle();
    end
    drive(1, 1, 1, 12'h000); #1;
    expect_out("halt.br", 0, 12'h000, 16'h0000, 12'h004, 1);
    next_cycle();
    drive(1, 1, 0, 12'h000); #1;
    expect_out("halt.redir", 0, 12'h000, 16'h0000, 12'h000, 0);
    next_cycle();
    drive(1, 1, 0, 12'h000); #1;
    expect_out("halt.resume", 1, 12'h000, 16'h0234, 12'h001, 0);
    next_cycle();
`else
    drive(1, 1, 0, 12'h000); #1;
    expect_out("f000.a", 1, 12'h003, 16'hF000, 12'h004, 0);
    next_cycle();
    drive(1, 1, 0, 12'h000); #1;
    expect_out("f000.b", 1, 12'h004, 16'h4444, 12'h005, 0);
    next_cycle();
`endif

    // Async reset between edges while streaming
    drive(1, 1, 0, 12'h000);
    #2;
    chk("areset.pre_valid", 16'(bus.inst_valid), 16'h0001);
    rst = 1'b1;
    #1;
    chk("areset.valid", 16'(bus.inst_valid), 16'h0000);
    chk("areset.addr",  16'(bus.addIM),      16'h0000);
    chk("areset.halted", 16'(bus.halted),    16'h0000);
    next_cycle();
    chk("areset.hold_valid", 16'(bus.inst_valid), 16'h0000);

    // Random phase
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 16'($urandom);
`ifdef FETCH_HALT_EN
      if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'hE;
`endif
    end
    rst = 1'b0;
    exp_pc     = 12'h000;
    prev_run   = 1'b0;
    prev_rdy   = 1'b0;
    prev_br    = 1'b0;
    prev_valid = 1'b0;
    prev_tgt   = 12'h000;

    for (int c = 0; c < 1500; c++) begin
      logic        r_run, r_rdy, r_br, obs_valid, e_valid, adv_exp;
      logic [11:0] r_tgt, e_addr;
      r_run = ($urandom_range(0, 3) != 0);
      r_rdy = ($urandom_range(0, 2) != 0);
      r_br  = ($urandom_range(0, 15) == 0);
      r_tgt = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) r_tgt = 12'hFFD + 12'($urandom_range(0, 4));
      drive(r_run, r_rdy, r_br, r_tgt);
      #1;

      if (prev_br)                     e_valid = 1'b0;
      else if (prev_valid & !prev_rdy) e_valid = 1'b1;
      else                             e_valid = prev_run;
      chk("rnd.valid", 16'(bus.inst_valid), 16'(e_valid));

      obs_valid = bus.inst_valid;
      if (obs_valid) begin
        chk("rnd.pc",   16'(bus.pc_out), 16'(exp_pc));
        chk("rnd.inst", bus.inst_out,    mem[exp_pc]);
      end
      adv_exp = r_run & (!obs_valid | r_rdy);
      e_addr  = (obs_valid & adv_exp) ? exp_pc + 12'd1 : exp_pc;
      chk("rnd.addr",   16'(bus.addIM),  16'(e_addr));
      chk("rnd.halted", 16'(bus.halted), 16'h0000);

      next_cycle();
      if (obs_valid & r_rdy) exp_pc = exp_pc + 12'd1;
      if (r_br) exp_pc = r_tgt;
      prev_run   = r_run;
      prev_rdy   = r_rdy;
      prev_br    = r_br;
      prev_tgt   = r_tgt;
      prev_valid = obs_valid;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000, fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port run  input  1  fetch enable; 0 = no new fetch issued.
REQ-005 SHALL have port addIM  output  12  read address to instmem; instmem read data appears on outIM one clock edge later.
REQ-006 SHALL have port outIM  input  16  instruction word returned by instmem.
REQ-007 SHALL have port inst_out  output  16  instruction to decode, driven directly from outIM.
REQ-008 SHALL have port inst_valid  output  1  inst_out/pc_out hold a valid instruction.
REQ-009 SHALL have port inst_ready  input  1  decode accepts inst_out this cycle.
REQ-010 SHALL have port pc_out  output  12  address of the instruction on inst_out.
REQ-011 SHALL have port br_taken  input  1  redirect request, one-cycle pulse.
REQ-012 SHALL have port br_target  input  12  redirect address, sampled when br_taken=1.
REQ-013 SHALL have port halted  output  1  fetch stopped by HALT opcode.

Function
REQ-014 SHALL hold registers pc_f (next fetch address), pc_d (address currently in outIM) and vld (outIM valid), with inst_valid=vld and pc_out=pc_d.
REQ-015 SHALL compute adv = run & !halted & (!vld | inst_ready) & !halt_hit.
REQ-016 SHALL drive addIM = pc_d when vld & !adv (hold, keeps outIM stable), else pc_f.
REQ-017 SHALL, on an edge with adv and no br_taken, set pc_d<=pc_f, pc_f<=pc_f+1, vld<=1: one instruction per cycle, one-cycle address-to-valid latency.
REQ-018 SHALL wrap pc_f from 12'hFFF to 12'h000 with no flag.
REQ-019 SHALL, on an edge with vld & inst_ready & !adv, clear vld.
REQ-020 SHALL, on an edge with vld & !inst_ready, hold pc_d, pc_f, vld and inst_out unchanged.
REQ-021 SHALL give br_taken priority over all other updates: pc_f<=br_target, vld<=0; an instruction handshaked in that cycle counts as consumed.
REQ-022 SHALL produce the first valid instruction from br_target two cycles after the br_taken edge (cycle 1: addIM=br_target; cycle 2: inst_valid=1, pc_out=br_target).
REQ-023 SHALL ignore run=0 for a pending valid instruction: it stays valid until handshaked.
REQ-024 SHALL never write instmem; the write port is owned by the program loader.

Reset
REQ-025 SHALL, while rst=1 (asynchronously), force pc_f=RESET_PC, pc_d=12'h000, vld=0, halted=0, so addIM=RESET_PC and inst_valid=0.
REQ-026 SHALL, on reset mid-fetch, drop any in-flight instruction without inst_valid asserting for it.

Configuration
REQ-027 SHALL, when FETCH_HALT_EN is defined, define halt_hit = vld & inst_ready & (inst_out[15:12]==4'hF); on that edge halted<=1, vld<=0, and pc_f is left at HALT address+1.
REQ-028 SHALL, when FETCH_HALT_EN is defined, clear halted only on br_taken (which then redirects per REQ-021) or rst.
REQ-029 SHALL, when FETCH_HALT_EN is not defined, tie halt_hit=0 and halted=0 and treat opcode 4'hF as an ordinary instruction.

Verification
REQ-030 SHALL cover streaming: mem[0..2]=16'h0234,16'h0381,16'h1111, run=1, inst_ready=1 after reset -> inst_valid from cycle 2, inst_out/pc_out = 0234/000, 0381/001, 1111/002 on consecutive cycles.
REQ-031 SHALL cover stall: inst_ready=0 for 3 cycles while 16'h0381@001 shown -> addIM=001, inst_out=16'h0381, pc_out=001 held; resumes with 16'h1111@002 the cycle after inst_ready=1.
REQ-032 SHALL cover redirect: br_taken=1, br_target=12'h008, mem[8]=16'h2222 -> inst_valid=0 next cycle, then 16'h2222 with pc_out=008.
REQ-033 SHALL cover wrap: br_target=12'hFFE, streaming -> pc_out sequence FFE, FFF, 000.
REQ-034 SHALL cover halt with FETCH_HALT_EN: mem[3]=16'hF000 consumed -> halted=1, inst_valid=0, addIM=004 steady; br_taken to 000 clears halted. Without macro, 16'hF000 streams normally.
REQ-035 SHALL cover async reset asserted between clock edges mid-stream -> inst_valid=0 and addIM=RESET_PC immediately, without waiting for clk.
